// File: rtl/rv_writeback_if.sv
// Memory-to-writeback bus: the instruction leaving Memory plus the register-file write port.
interface rv_writeback_if #(
    parameter int INSTRET_W = 64
);
    logic                 mem_valid;
    logic [4:0]           mem_rd;
    logic                 mem_rd_wr_en;
    logic [1:0]           mem_wb_sel;
    logic [31:0]          mem_alu_result;
    logic [31:0]          mem_pc_plus4;
    logic [2:0]           mem_funct3;
    logic [31:0]          mem_load_data;
    logic                 stall;
    logic                 flush;
    logic [4:0]           rd;
    logic [31:0]          rd_wr_data;
    logic                 rd_wr_en;
    logic                 wb_valid;
    logic                 load_fault;
    logic [INSTRET_W-1:0] instret;

    modport master (
        output mem_valid, mem_rd, mem_rd_wr_en, mem_wb_sel, mem_alu_result,
               mem_pc_plus4, mem_funct3, mem_load_data, stall, flush,
        input  rd, rd_wr_data, rd_wr_en, wb_valid, load_fault, instret
    );

    modport slave (
        input  mem_valid, mem_rd, mem_rd_wr_en, mem_wb_sel, mem_alu_result,
               mem_pc_plus4, mem_funct3, mem_load_data, stall, flush,
        output rd, rd_wr_data, rd_wr_en, wb_valid, load_fault, instret
    );
endinterface

// File: rtl/rv_writeback.sv
// RV32I writeback: selects ALU/load/link result, registers the regfile write port (1 cycle).
// Never stalls; stall/flush from Memory simply insert a bubble.
module rv_writeback #(
    parameter int INSTRET_W = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    rv_writeback_if.slave wb
);
    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [1:0]           off;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [31:0]          ld_ext;
    logic [31:0]          result;
    logic                 misaligned;
    logic                 illegal;
    logic                 fault;
    logic                 wr_en;
    logic                 capture;

    logic [4:0]           rd_q;
    logic [31:0]          data_q;
    logic                 wr_en_q;
    logic                 valid_q;
    logic                 fault_q;
    logic [INSTRET_W-1:0] instret_q;

    always_comb begin
        off        = wb.mem_alu_result[1:0];
        ld_byte    = wb.mem_load_data[7:0];
        ld_half    = off[1] ? wb.mem_load_data[31:16] : wb.mem_load_data[15:0];
        ld_ext     = wb.mem_load_data;
        misaligned = 1'b0;
        illegal    = 1'b0;

        case (off)
            2'd0:    ld_byte = wb.mem_load_data[7:0];
            2'd1:    ld_byte = wb.mem_load_data[15:8];
            2'd2:    ld_byte = wb.mem_load_data[23:16];
            default: ld_byte = wb.mem_load_data[31:24];
        endcase

        case (wb.mem_funct3)
            F3_LB:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU: ld_ext = {24'b0, ld_byte};
            F3_LH: begin
                ld_ext     = {{16{ld_half[15]}}, ld_half};
                misaligned = off[0];
            end
            F3_LHU: begin
                ld_ext     = {16'b0, ld_half};
                misaligned = off[0];
            end
            F3_LW: begin
                ld_ext     = wb.mem_load_data;
                misaligned = |off;
            end
            default: illegal = 1'b1;
        endcase

        // funct3 only matters for loads; other selects can never fault
        fault = (wb.mem_wb_sel == SEL_LOAD) & (misaligned | illegal);

        case (wb.mem_wb_sel)
            SEL_ALU:  result = wb.mem_alu_result;
            SEL_LOAD: result = fault ? wb.mem_load_data : ld_ext;
            SEL_LINK: result = wb.mem_pc_plus4;
            default:  result = wb.mem_alu_result;
        endcase

        // x0 writes are dropped here so forwarding can trust rd_wr_en alone
        wr_en   = wb.mem_rd_wr_en & (|wb.mem_rd) & ~fault & (wb.mem_wb_sel != SEL_NONE);
        capture = wb.mem_valid & ~wb.stall & ~wb.flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q      <= '0;
            data_q    <= '0;
            wr_en_q   <= 1'b0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            instret_q <= '0;
        end else if (capture) begin
            rd_q    <= wb.mem_rd;
            data_q  <= result;
            wr_en_q <= wr_en;
            valid_q <= 1'b1;
            fault_q <= fault;
            if (!fault) begin
                instret_q <= instret_q + INSTRET_W'(1);
            end
        end else begin
            wr_en_q <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end
    end

    assign wb.rd         = rd_q;
    assign wb.rd_wr_data = data_q;
    assign wb.rd_wr_en   = wr_en_q;
    assign wb.wb_valid   = valid_q;
    assign wb.load_fault = fault_q;
    assign wb.instret    = instret_q;
endmodule

// File: tb/tb_rv_writeback.sv
// Directed bench for rv_writeback: spec-level model checked every cycle plus literal expectations.
module tb_rv_writeback;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    rv_writeback_if #(.INSTRET_W(64)) bus ();
    rv_writeback_if #(.INSTRET_W(4))  sbus ();

    rv_writeback #(.INSTRET_W(64)) dut   (.clk(clk), .rst_n(rst_n), .wb(bus));
    // narrow counter instance shares stimulus so the wrap can be reached quickly
    rv_writeback #(.INSTRET_W(4))  dut_s (.clk(clk), .rst_n(rst_n), .wb(sbus));

    assign sbus.mem_valid      = bus.mem_valid;
    assign sbus.mem_rd         = bus.mem_rd;
    assign sbus.mem_rd_wr_en   = bus.mem_rd_wr_en;
    assign sbus.mem_wb_sel     = bus.mem_wb_sel;
    assign sbus.mem_alu_result = bus.mem_alu_result;
    assign sbus.mem_pc_plus4   = bus.mem_pc_plus4;
    assign sbus.mem_funct3     = bus.mem_funct3;
    assign sbus.mem_load_data  = bus.mem_load_data;
    assign sbus.stall          = bus.stall;
    assign sbus.flush          = bus.flush;

    int n_vec = 0;
    int n_bad = 0;
    logic chk_on = 1'b0;

    typedef struct packed {
        logic [31:0] data;
        logic        fault;
        logic        wen;
    } exp_t;

    // Result straight from the ISA rules: shift the word down by the byte offset, mask to the access size.
    function automatic exp_t predict(input logic [4:0] r, input logic we, input logic [1:0] sel,
                                     input logic [31:0] alu, input logic [31:0] pc4,
                                     input logic [31:0] ld, input logic [2:0] f3);
        exp_t e;
        int   size;
        int   off;
        logic [31:0] w;
        off     = int'(alu[1:0]);
        e.fault = 1'b0;
        e.data  = alu;
        if (sel == 2'b10) e.data = pc4;
        if (sel == 2'b01) begin
            size = 1 << f3[1:0];
            if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (off % size) != 0) begin
                e.fault = 1'b1;
                e.data  = ld;
            end else begin
                w = ld >> (8 * off);
                if (size == 1) w = w & 32'h0000_00FF;
                if (size == 2) w = w & 32'h0000_FFFF;
                if (!f3[2] && size == 1 && w[7])  w = w | 32'hFFFF_FF00;
                if (!f3[2] && size == 2 && w[15]) w = w | 32'hFFFF_0000;
                e.data = w;
            end
        end
        e.wen = we && (r != 5'd0) && !e.fault && (sel != 2'b11);
        return e;
    endfunction

    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_wen, m_valid, m_fault;
    logic [63:0] m_cnt;
    exp_t        m_e;

    assign m_e = predict(bus.mem_rd, bus.mem_rd_wr_en, bus.mem_wb_sel, bus.mem_alu_result,
                         bus.mem_pc_plus4, bus.mem_load_data, bus.mem_funct3);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rd <= '0; m_data <= '0; m_wen <= 1'b0; m_valid <= 1'b0; m_fault <= 1'b0; m_cnt <= '0;
        end else if (bus.mem_valid && !bus.stall && !bus.flush) begin
            m_rd    <= bus.mem_rd;
            m_data  <= m_e.data;
            m_wen   <= m_e.wen;
            m_valid <= 1'b1;
            m_fault <= m_e.fault;
            m_cnt   <= m_cnt + (m_e.fault ? 64'd0 : 64'd1);
        end else begin
            m_wen <= 1'b0; m_valid <= 1'b0; m_fault <= 1'b0;
        end
    end

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                cmp("m.rd",         64'(bus.rd),         64'(m_rd));
                cmp("m.rd_wr_data", 64'(bus.rd_wr_data), 64'(m_data));
                cmp("m.rd_wr_en",   64'(bus.rd_wr_en),   64'(m_wen));
                cmp("m.wb_valid",   64'(bus.wb_valid),   64'(m_valid));
                cmp("m.load_fault", 64'(bus.load_fault), 64'(m_fault));
                cmp("m.instret",    bus.instret,         m_cnt);
                cmp("m.instret4",   64'(sbus.instret),   64'(m_cnt[3:0]));
            end
        end
    end

    task automatic send(input logic v, input logic [4:0] r, input logic we, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3,
                        input logic [31:0] ld, input logic st, input logic fl);
        bus.mem_valid = v;   bus.mem_rd = r;         bus.mem_rd_wr_en = we;
        bus.mem_wb_sel = sel; bus.mem_alu_result = alu; bus.mem_pc_plus4 = pc4;
        bus.mem_funct3 = f3; bus.mem_load_data = ld; bus.stall = st; bus.flush = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic alu_op(input logic [4:0] r, input logic [31:0] val);
        send(1'b1, r, 1'b1, 2'b00, val, 32'h0, 3'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    endtask

    task automatic load_op(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d);
        send(1'b1, 5'd7, 1'b1, 2'b01, addr, 32'h0, f3, d, 1'b0, 1'b0);
    endtask

    task automatic idle();
        send(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0);
    endtask

    logic [63:0] base;
    localparam logic [31:0] LD = 32'h80FF_7F01;

    initial begin
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_rd_wr_en = 1'b0; bus.mem_wb_sel = '0;
        bus.mem_alu_result = '0; bus.mem_pc_plus4 = '0; bus.mem_funct3 = '0;
        bus.mem_load_data = '0; bus.stall = 1'b0; bus.flush = 1'b0;
        #1 rst_n = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);
        cmp("reset.instret", bus.instret, 64'd0);
        cmp("reset.wb_valid", 64'(bus.wb_valid), 64'd0);
        rst_n = 1'b1;

        // Mid-stream asynchronous reset
        alu_op(5'd3, 32'hAAAA_5555);
        alu_op(5'd4, 32'h1111_2222);
        #2 rst_n = 1'b0;
        #1;
        cmp("arst.rd",         64'(bus.rd),         64'd0);
        cmp("arst.rd_wr_data", 64'(bus.rd_wr_data), 64'd0);
        cmp("arst.rd_wr_en",   64'(bus.rd_wr_en),   64'd0);
        cmp("arst.instret",    bus.instret,         64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        alu_op(5'd5, 32'h0000_1234);
        cmp("first.rd",         64'(bus.rd),         64'd5);
        cmp("first.rd_wr_data", 64'(bus.rd_wr_data), 64'h1234);
        cmp("first.rd_wr_en",   64'(bus.rd_wr_en),   64'd1);
        cmp("first.instret",    bus.instret,         64'd1);

        // Load extension
        load_op(3'b000, 32'h2003, LD); cmp("lb.off3",  64'(bus.rd_wr_data), 64'hFFFF_FF80);
        load_op(3'b100, 32'h2003, LD); cmp("lbu.off3", 64'(bus.rd_wr_data), 64'h0000_0080);
        load_op(3'b001, 32'h2002, LD); cmp("lh.off2",  64'(bus.rd_wr_data), 64'hFFFF_80FF);
        load_op(3'b101, 32'h2002, LD); cmp("lhu.off2", 64'(bus.rd_wr_data), 64'h0000_80FF);
        load_op(3'b000, 32'h2001, LD); cmp("lb.off1",  64'(bus.rd_wr_data), 64'h0000_007F);
        load_op(3'b010, 32'h2000, LD); cmp("lw.off0",  64'(bus.rd_wr_data), 64'h80FF_7F01);

        // Misaligned and illegal loads, back to back
        base = bus.instret;
        load_op(3'b010, 32'h1002, LD);
        cmp("lw.mis.fault", 64'(bus.load_fault), 64'd1);
        cmp("lw.mis.wen",   64'(bus.rd_wr_en),   64'd0);
        cmp("lw.mis.valid", 64'(bus.wb_valid),   64'd1);
        cmp("lw.mis.data",  64'(bus.rd_wr_data), 64'(LD));
        load_op(3'b001, 32'h1001, LD);
        cmp("lh.mis.fault", 64'(bus.load_fault), 64'd1);
        cmp("lh.mis.cnt",   bus.instret,         base);
        load_op(3'b001, 32'h1002, LD);
        cmp("lh.ok.fault",  64'(bus.load_fault), 64'd0);
        cmp("lh.ok.wen",    64'(bus.rd_wr_en),   64'd1);
        cmp("lh.ok.cnt",    bus.instret,         base + 64'd1);
        load_op(3'b011, 32'h1000, LD);
        cmp("illegal.fault", 64'(bus.load_fault), 64'd1);
        idle();
        cmp("fault.pulse",  64'(bus.load_fault), 64'd0);

        // Link value and x0 suppression
        base = bus.instret;
        send(1'b1, 5'd0, 1'b1, 2'b10, 32'h0, 32'h0000_0104, 3'd0, 32'h0, 1'b0, 1'b0);
        cmp("jal.x0.wen", 64'(bus.rd_wr_en), 64'd0);
        cmp("jal.x0.cnt", bus.instret,       base + 64'd1);
        send(1'b1, 5'd1, 1'b1, 2'b10, 32'h0, 32'h0000_0104, 3'd0, 32'h0, 1'b0, 1'b0);
        cmp("jal.x1.data", 64'(bus.rd_wr_data), 64'h104);
        cmp("jal.x1.wen",  64'(bus.rd_wr_en),   64'd1);
        // Reserved select with funct3 that would be illegal for a load: no write, no fault
        send(1'b1, 5'd9, 1'b1, 2'b11, 32'h55, 32'h0, 3'd7, 32'h0, 1'b0, 1'b0);
        cmp("sel11.wen",   64'(bus.rd_wr_en),   64'd0);
        cmp("sel11.fault", 64'(bus.load_fault), 64'd0);

        // Stall and flush bubbles
        base = bus.instret;
        alu_op(5'd10, 32'h10);
        cmp("sf.1.valid", 64'(bus.wb_valid), 64'd1);
        send(1'b1, 5'd11, 1'b1, 2'b00, 32'h11, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);
        cmp("sf.2.valid", 64'(bus.wb_valid), 64'd0);
        cmp("sf.2.wen",   64'(bus.rd_wr_en), 64'd0);
        cmp("sf.2.rd",    64'(bus.rd),       64'd10);
        alu_op(5'd12, 32'h12);
        send(1'b1, 5'd13, 1'b1, 2'b00, 32'h13, 32'h0, 3'd0, 32'h0, 1'b0, 1'b1);
        cmp("sf.4.valid", 64'(bus.wb_valid), 64'd0);
        cmp("sf.4.data",  64'(bus.rd_wr_data), 64'h12);
        cmp("sf.cnt",     bus.instret,       base + 64'd2);
        send(1'b1, 5'd14, 1'b1, 2'b00, 32'h14, 32'h0, 3'd0, 32'h0, 1'b1, 1'b1);
        cmp("stall+flush.valid", 64'(bus.wb_valid), 64'd0);
        send(1'b1, 5'd7, 1'b1, 2'b01, 32'h1003, 32'h0, 3'b010, LD, 1'b0, 1'b1);
        cmp("flush+fault.fault", 64'(bus.load_fault), 64'd0);
        cmp("flush+fault.valid", 64'(bus.wb_valid),   64'd0);

        // Counter wrap on the narrow instance
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) alu_op(5'd2, 32'(i));
        cmp("wrap.pre",  64'(sbus.instret), 64'hF);
        alu_op(5'd2, 32'h99);
        cmp("wrap.zero", 64'(sbus.instret), 64'h0);
        cmp("wrap.wide", bus.instret,       64'd16);
        idle();

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
